// File: rtl/bram_ctrl_pkg.sv
// Shared types and line-wrap helper for the bus-to-block-RAM responder.
package bram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WR_BEAT,
    WR_WAIT
  } state_t;

  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = 2;

  // Only the word-in-line bits advance; the line address never changes.
  function automatic logic [BEAT_W-1:0] next_beat_addr(input logic [BEAT_W-1:0] i_lo);
    return i_lo + 2'd1;
  endfunction

endpackage

// File: rtl/bram_ctrl.sv
// Bus responder for a simple dual-port BRAM: single or 4-beat wrapping bursts, reads ack from T+2 back-to-back, writes one beat per 2 cycles.
// Define BRAM_CTRL_ERR_EN to flag out-of-range beats on bus_err instead of aliasing modulo 2^AW.
module bram_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int SIZE = 1024,
  parameter int COLS = 4,
  parameter int AW   = $clog2(SIZE),
  parameter int DW   = COLS * 8,
  parameter int BAW  = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_req,
  input  logic            bus_we,
  input  logic            bus_burst,
  input  logic [BAW-1:0]  bus_addr,
  input  logic [COLS-1:0] bus_sel,
  input  logic [DW-1:0]   bus_wdata,
  output logic            bus_ack,
  output logic            bus_err,
  output logic [DW-1:0]   bus_rdata,
  output logic [COLS-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic [AW-1:0]   mem_raddr,
  input  logic [DW-1:0]   mem_rdata
);

  state_t            r_state;
  logic [BAW-1:0]    r_addr;   // next beat address still to be issued
  logic              r_burst;
  logic              r_oor;
  logic [BEAT_W-1:0] r_beat;   // beats completed on the bus side
  logic [BEAT_W:0]   r_iss;    // read addresses already sent to the RAM
  logic              r_ack;
  logic              r_err;
  logic [DW-1:0]     r_rdata;
  logic [COLS-1:0]   r_wstrb;
  logic [AW-1:0]     r_waddr;
  logic [DW-1:0]     r_wdata;
  logic [AW-1:0]     r_raddr;

  logic [BAW-1:0]    w_start_next;
  logic [BAW-1:0]    w_next;
  logic [BEAT_W-1:0] w_last;
  logic              w_req_oor;

  assign w_start_next = {bus_addr[BAW-1:BEAT_W], next_beat_addr(bus_addr[BEAT_W-1:0])};
  assign w_next       = {r_addr[BAW-1:BEAT_W], next_beat_addr(r_addr[BEAT_W-1:0])};
  assign w_last       = r_burst ? BEAT_W'(BURST_LEN - 1) : '0;

  // SIZE is a whole number of lines, so one range check covers every beat.
`ifdef BRAM_CTRL_ERR_EN
  assign w_req_oor = (bus_addr >= BAW'(SIZE));
`else
  assign w_req_oor = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_burst <= 1'b0;
      r_oor   <= 1'b0;
      r_beat  <= '0;
      r_iss   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_wstrb <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_raddr <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_wstrb <= '0;
      case (r_state)
        IDLE: begin
          if (bus_req) begin
            r_burst <= bus_burst;
            r_oor   <= w_req_oor;
            r_beat  <= '0;
            r_addr  <= w_start_next;
            if (bus_we) begin
              r_wstrb <= w_req_oor ? '0 : bus_sel;
              r_wdata <= bus_wdata;
              r_waddr <= bus_addr[AW-1:0];
              r_ack   <= ~w_req_oor;
              r_err   <= w_req_oor;
              r_state <= WR_BEAT;
            end else begin
              r_raddr <= bus_addr[AW-1:0];
              r_iss   <= (BEAT_W+1)'(1);
              r_state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE, RD_DATA: begin
          if (r_iss <= {1'b0, w_last}) begin
            r_raddr <= r_addr[AW-1:0];
            r_addr  <= w_next;
            r_iss   <= r_iss + 1'b1;
          end
          if (r_state == RD_ISSUE) begin
            r_state <= RD_DATA;
          end else begin
            r_ack   <= ~r_oor;
            r_err   <= r_oor;
            r_rdata <= r_oor ? '0 : mem_rdata;
            r_beat  <= r_beat + 1'b1;
            if (r_beat == w_last) r_state <= IDLE;
          end
        end
        WR_BEAT: begin
          r_beat  <= r_beat + 1'b1;
          r_state <= (r_beat == w_last) ? IDLE : WR_WAIT;
        end
        WR_WAIT: begin
          r_wstrb <= r_oor ? '0 : bus_sel;
          r_wdata <= bus_wdata;
          r_waddr <= r_addr[AW-1:0];
          r_addr  <= w_next;
          r_ack   <= ~r_oor;
          r_err   <= r_oor;
          r_state <= WR_BEAT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_ack   = r_ack;
  assign bus_err   = r_err;
  assign bus_rdata = r_rdata;
  assign mem_wstrb = r_wstrb;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign mem_raddr = r_raddr;

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed bench for bram_ctrl with a registered-read byte-lane RAM model attached.
module tb_bram_ctrl;
  localparam int SIZE = 1024;
  localparam int COLS = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int BAW  = 30;
`ifdef BRAM_CTRL_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            bus_req, bus_we, bus_burst;
  logic [BAW-1:0]  bus_addr;
  logic [COLS-1:0] bus_sel;
  logic [DW-1:0]   bus_wdata;
  logic            bus_ack, bus_err;
  logic [DW-1:0]   bus_rdata;
  logic [COLS-1:0] mem_wstrb;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic [AW-1:0]   mem_raddr;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0]   ram [SIZE];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_ctrl #(.SIZE(SIZE), .COLS(COLS), .AW(AW), .DW(DW), .BAW(BAW)) dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_burst(bus_burst),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .mem_wstrb(mem_wstrb), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    for (int i = 0; i < COLS; i++)
      if (mem_wstrb[i]) ram[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= ram[mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"},   32'(bus_ack),   0);
    chk({tag, "_err"},   32'(bus_err),   0);
    chk({tag, "_rdata"}, bus_rdata,      0);
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 0);
    chk({tag, "_waddr"}, 32'(mem_waddr), 0);
    chk({tag, "_wdata"}, mem_wdata,      0);
    chk({tag, "_raddr"}, 32'(mem_raddr), 0);
  endtask

  // Beat k uses sels[4k+:4] / dats[32k+:32]; exp_ba holds the expected RAM index per beat.
  task automatic wr(input logic [BAW-1:0] a, input logic brst, input logic [15:0] sels,
                    input logic [127:0] dats, input logic [39:0] exp_ba, input logic exp_err);
    int n;
    n = brst ? 4 : 1;
    bus_req = 1'b1; bus_we = 1'b1; bus_burst = brst; bus_addr = a;
    bus_sel = sels[3:0]; bus_wdata = dats[31:0];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("wr_ack",   32'(bus_ack),   32'(!exp_err));
      chk("wr_err",   32'(bus_err),   32'(exp_err));
      chk("wr_wstrb", 32'(mem_wstrb), exp_err ? 32'd0 : 32'(sels[4*k +: 4]));
      chk("wr_waddr", 32'(mem_waddr), 32'(exp_ba[10*k +: 10]));
      if (k == n - 1) bus_req = 1'b0;
      else begin
        bus_sel = sels[4*(k+1) +: 4]; bus_wdata = dats[32*(k+1) +: 32];
      end
      @(negedge clk);
      chk("wr_gap_ack",   32'(bus_ack),   0);
      chk("wr_gap_wstrb", 32'(mem_wstrb), 0);
    end
  endtask

  task automatic rd(input logic [BAW-1:0] a, input logic brst, input logic [127:0] exp);
    int n;
    n = brst ? 4 : 1;
    bus_req = 1'b1; bus_we = 1'b0; bus_burst = brst; bus_addr = a;
    @(negedge clk);
    chk("rd_raddr0", 32'(mem_raddr), 32'(a[AW-1:0]));
    chk("rd_ack_t0", 32'(bus_ack), 0);
    @(negedge clk);
    chk("rd_ack_t1", 32'(bus_ack), 0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rd_ack",   32'(bus_ack), 1);
      chk("rd_rdata", bus_rdata, exp[32*k +: 32]);
      if (k == n - 1) bus_req = 1'b0;
    end
    @(negedge clk);
    chk("rd_end_ack",   32'(bus_ack), 0);
    chk("rd_hold_data", bus_rdata, exp[32*(n-1) +: 32]);
  endtask

  initial begin
    rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_burst = 1'b0;
    bus_addr = '0; bus_sel = '0; bus_wdata = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // single write / read and byte lanes
    wr(30'h010, 1'b0, 16'h000F, 128'hDEADBEEF, 40'h010, 1'b0);
    chk("ram_010", ram[10'h010], 32'hDEADBEEF);
    rd(30'h010, 1'b0, 128'hDEADBEEF);
    wr(30'h010, 1'b0, 16'h0002, 128'h0000AA00, 40'h010, 1'b0);
    rd(30'h010, 1'b0, 128'hDEADAAEF);
    wr(30'h010, 1'b0, 16'h0000, 128'hFFFFFFFF, 40'h010, 1'b0);
    rd(30'h010, 1'b0, 128'hDEADAAEF);

    // wrapping bursts
    wr(30'h020, 1'b1, 16'hFFFF, {32'd3, 32'd2, 32'd1, 32'd0},
       {10'h023, 10'h022, 10'h021, 10'h020}, 1'b0);
    rd(30'h022, 1'b1, {32'd1, 32'd0, 32'd3, 32'd2});
    wr(30'h041, 1'b1, 16'hFFFF, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA},
       {10'h040, 10'h043, 10'h042, 10'h041}, 1'b0);
    chk("ram_041", ram[10'h041], 32'hAAAAAAAA);
    chk("ram_042", ram[10'h042], 32'hBBBBBBBB);
    chk("ram_043", ram[10'h043], 32'hCCCCCCCC);
    chk("ram_040", ram[10'h040], 32'hDDDDDDDD);

    // reset after the second write ack of a burst
    wr(30'h080, 1'b1, 16'hFFFF, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
       {10'h083, 10'h082, 10'h081, 10'h080}, 1'b0);
    bus_req = 1'b1; bus_we = 1'b1; bus_burst = 1'b1; bus_addr = 30'h080;
    bus_sel = 4'hF; bus_wdata = 32'h55555555;
    @(negedge clk);
    chk("rstb_ack0", 32'(bus_ack), 1);
    bus_wdata = 32'h66666666;
    @(negedge clk);
    @(negedge clk);
    chk("rstb_ack1", 32'(bus_ack), 1);
    rst = 1'b1; bus_req = 1'b0;
    @(negedge clk);
    chk_quiet("rstb_after");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstb_ack_none", 32'(bus_ack), 0);
    chk("ram_080", ram[10'h080], 32'h55555555);
    chk("ram_081", ram[10'h081], 32'h66666666);
    chk("ram_082", ram[10'h082], 32'h33333333);
    chk("ram_083", ram[10'h083], 32'h44444444);
    rd(30'h081, 1'b0, 128'h66666666);

    // address beyond SIZE: aliases to word 0, or errors when the check is built in
    wr(30'h000, 1'b0, 16'h000F, 128'h12345678, 40'h000, 1'b0);
    wr(30'h400, 1'b0, 16'h000F, 128'hCAFEF00D, 40'h000, ERR);
    chk("ram_000", ram[10'h000], ERR ? 32'h12345678 : 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
